// File: rtl/schwap_pkg.sv
// schwap_pkg: shared types and constants for the schwap register-bank sequencer
package schwap_pkg;

    localparam int BANK_W = 4;

    // Address bits [3:2] selecting the swappable registers 12..15
    localparam logic [1:0] SCHWAP_WINDOW = 2'b11;

    typedef logic [BANK_W-1:0] bank_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_DRAIN,
        S_SETUP,
        S_PULSE,
        S_DONE
    } state_e;

endpackage

// File: rtl/schwap_pulse_gen.sv
// schwap_pulse_gen: loadable down-counter producing a SETTLE_CYCLES-wide registered strobe
module schwap_pulse_gen #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load_i,
    output logic pulse_o,
    output logic last_o
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pulse_q;

    // Reload on request, otherwise count down to zero and park there
    always_comb begin
        cnt_d = load_i ? CW'(SETTLE_CYCLES) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
    end

    // Strobe is a flop so the register file sees a glitch-free edge; async clear drops it at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= cnt_d != '0;
        end
    end

    assign pulse_o = pulse_q;
    assign last_o  = cnt_q == CW'(1);

endmodule

// File: rtl/schwap_ctrl.sv
// schwap_ctrl: context-switch sequencer and write gate for the schwappable register bank
module schwap_ctrl
    import schwap_pkg::*;
#(
    parameter int NUM_BANKS     = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        swapReq,
    input  logic [3:0]  swapBank,
    output logic        swapAck,
    output logic        swapErr,
    input  logic        cpuWrite,
    input  logic [3:0]  cpuWriteAddr,
    output logic        writeOut,
    output logic        stall,
    output logic        busy,
    output logic [3:0]  curBank,
    output logic [3:0]  schwapReg,
    output logic        schwapClk
);

    state_e state_q, state_d;
    bank_t  tgt_q, tgt_d;
    bank_t  cur_q, cur_d;
    bank_t  reg_q, reg_d;
    logic   err_d;
    logic   ack_q, err_q, stall_q, busy_q;
    logic   boot_q, boot_d;
    logic   load, last, in_window, gate_state;

    schwap_pulse_gen #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_pulse (
        .clk    (clk),
        .reset_n(reset_n),
        .load_i (load),
        .pulse_o(schwapClk),
        .last_o (last)
    );

    // Next state, target latch and bank bookkeeping; the reset-time swap is not acknowledged
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cur_d   = cur_q;
        err_d   = 1'b0;
        load    = 1'b0;
        boot_d  = (state_q == S_DONE) ? 1'b0 : boot_q;
        case (state_q)
            S_INIT: begin
                tgt_d   = '0;
                state_d = S_SETUP;
            end
            S_IDLE: begin
                if (swapReq) begin
                    if (int'(swapBank) >= NUM_BANKS) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (swapBank == cur_q) begin
                        state_d = S_DONE;
                    end else begin
                        tgt_d   = swapBank;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: state_d = S_SETUP;
            S_SETUP: begin
                load    = 1'b1;
                state_d = S_PULSE;
            end
            S_PULSE: begin
                if (last) begin
                    cur_d   = tgt_q;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
        reg_d = (state_d == S_SETUP) ? tgt_d : reg_q;
    end

    // Registered state and outputs, all forced to their safe values by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
            tgt_q   <= '0;
            cur_q   <= '0;
            reg_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 1'b1;
            busy_q  <= 1'b1;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            reg_q   <= reg_d;
            ack_q   <= (state_d == S_DONE) && !boot_q;
            err_q   <= err_d;
            stall_q <= state_d != S_IDLE;
            busy_q  <= state_d != S_IDLE;
            boot_q  <= boot_d;
        end
    end

    // Write enable stays combinational so a writeback is never delayed; it is gated from registered state only
    always_comb begin
        in_window  = cpuWriteAddr >= {SCHWAP_WINDOW, 2'b00};
        gate_state = (state_q == S_SETUP) || (state_q == S_PULSE) ||
                     (state_q == S_DONE)  || (state_q == S_INIT);
        writeOut   = cpuWrite && !(gate_state && in_window);
    end

    assign swapAck   = ack_q;
    assign swapErr   = err_q;
    assign stall     = stall_q;
    assign busy      = busy_q;
    assign curBank   = cur_q;
    assign schwapReg = reg_q;

endmodule

// File: tb/tb_schwap_ctrl.sv
// tb_schwap_ctrl: randomized self-checking bench against a timeline model of the swap protocol
module tb_schwap_ctrl;

    localparam int NB = 12;
    localparam int S  = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       swapReq = 1'b0;
    logic [3:0] swapBank = '0;
    logic       cpuWrite = 1'b0;
    logic [3:0] cpuWriteAddr = '0;
    logic       swapAck, swapErr, writeOut, stall, busy, schwapClk;
    logic [3:0] curBank, schwapReg;

    int checks = 0;
    int errors = 0;
    int mcur = 0;
    int mreg = 0;
    int cyc = 0;
    int ack_cyc[$];

    schwap_ctrl #(
        .NUM_BANKS    (NB),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .swapReq     (swapReq),
        .swapBank    (swapBank),
        .swapAck     (swapAck),
        .swapErr     (swapErr),
        .cpuWrite    (cpuWrite),
        .cpuWriteAddr(cpuWriteAddr),
        .writeOut    (writeOut),
        .stall       (stall),
        .busy        (busy),
        .curBank     (curBank),
        .schwapReg   (schwapReg),
        .schwapClk   (schwapClk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic rand_wr();
        cpuWrite     = 1'($urandom_range(0, 1));
        cpuWriteAddr = 4'($urandom_range(0, 15));
    endtask

    // Registers 12..15 are protected whenever the bank may be mid-change
    task automatic check_wr(input bit protect);
        check("writeOut", writeOut, cpuWrite && !(protect && cpuWriteAddr >= 4'd12));
    endtask

    // Reset-time swap to bank 0: cycle 0 is INIT, strobe high cycles 2..1+S, stall low from 3+S
    task automatic check_boot();
        for (int c = 0; c <= 3 + S; c++) begin
            if (c > 0) @(negedge clk);
            rand_wr();
            #1;
            check("boot_clk", schwapClk, (c >= 2 && c < 2 + S));
            check("boot_stall", stall, c < 3 + S);
            check("boot_busy", busy, c < 3 + S);
            check("boot_ack", swapAck, 0);
            check("boot_reg", schwapReg, 0);
            check("boot_cur", curBank, 0);
            check_wr(c < 3 + S);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rand_wr();
            #1;
            check("idle_busy", busy, 0);
            check("idle_stall", stall, 0);
            check("idle_clk", schwapClk, 0);
            check("idle_ack", swapAck, 0);
            check("idle_reg", schwapReg, mreg);
            check("idle_cur", curBank, mcur);
            check_wr(0);
        end
    endtask

    // One request: short path acks next cycle, a real swap acks 3+S cycles after sampling
    task automatic do_swap(input int b, input bit dir);
        bit shortp;
        int lat;
        shortp = (b >= NB) || (b == mcur);
        lat    = shortp ? 1 : 3 + S;
        @(negedge clk);
        swapReq  = 1'b1;
        swapBank = 4'(b);
        rand_wr();
        #1;
        check("req_busy", busy, 0);
        check_wr(0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == lat) swapReq = 1'b0;
            rand_wr();
            if (dir) begin
                cpuWrite     = 1'b1;
                cpuWriteAddr = (k == 3) ? 4'd4 : 4'd13;
            end
            #1;
            check("ack", swapAck, k == lat);
            check("err", swapErr, (k == lat) && (b >= NB));
            check("clk", schwapClk, !shortp && k >= 3 && k <= 2 + S);
            check("stall", stall, 1);
            check("busy", busy, 1);
            check("reg", schwapReg, (!shortp && k >= 2) ? b : mreg);
            check("cur", curBank, (!shortp && k == lat) ? b : mcur);
            check_wr(shortp ? 1'b1 : k >= 2);
            if (k == lat) ack_cyc.push_back(cyc);
        end
        if (!shortp) begin
            mcur = b;
            mreg = b;
        end
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_clk", schwapClk, 0);
        check("rst_stall", stall, 1);
        check("rst_busy", busy, 1);
        check("rst_ack", swapAck, 0);
        check("rst_err", swapErr, 0);
        check("rst_cur", curBank, 0);
        check("rst_reg", schwapReg, 0);
        @(negedge clk);
        reset_n = 1'b1;
        check_boot();
        idle_cycles(2);

        do_swap(5, 1'b1);
        idle_cycles(1);
        do_swap(5, 1'b0);
        idle_cycles(1);
        do_swap(14, 1'b0);
        check("illegal_cur", curBank, 5);

        ack_cyc.delete();
        do_swap(2, 1'b0);
        do_swap(7, 1'b0);
        check("b2b_gap", ack_cyc[1] - ack_cyc[0], 4 + S);
        check("b2b_cur", curBank, 7);

        for (int n = 0; n < 60; n++) begin
            int b;
            b = ($urandom_range(0, 3) == 0) ? mcur : $urandom_range(0, 15);
            do_swap(b, 1'b0);
            idle_cycles($urandom_range(0, 3));
        end

        // Reset while the strobe is high
        @(negedge clk);
        swapReq  = 1'b1;
        swapBank = 4'((mcur + 1) % NB);
        for (int k = 1; k <= 3; k++) @(negedge clk);
        #1;
        check("mid_clk_hi", schwapClk, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_clk", schwapClk, 0);
        check("mid_cur", curBank, 0);
        check("mid_reg", schwapReg, 0);
        check("mid_stall", stall, 1);
        check("mid_busy", busy, 1);
        swapReq = 1'b0;
        mcur = 0;
        mreg = 0;
        @(negedge clk);
        reset_n = 1'b1;
        check_boot();
        idle_cycles(2);
        do_swap(9, 1'b0);
        idle_cycles(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
